alu_seq_acc: RTL and testbench
==============================

# alu_seq_acc

Parametrised sequential ALU with an internal accumulator, a valid/ready operand handshake, a registered result with flags, and an iterative shift-add multiplier. It generalises the team's purely combinational 8-bit ALU wrapper: width is parametrised, and it adds accumulator chaining and a multi-cycle multiply. It sits between the top-level pin mapping and the I/O registers. It accepts one operation per handshake and emits one result pulse per accepted operation.

## Interface
- WIDTH, 8: operand, result and accumulator width (legal range 4..16).
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  global enable; low freezes every register.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; equals (state==IDLE) & ena & rst_n.
- op  in  3  opcode, see Operation.
- use_acc  in  1  1: operand A is the accumulator; 0: operand A is port a.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  one-cycle result pulse.
- result  out  WIDTH  registered result, held until the next completion.
- carry  out  1  carry / no-borrow / multiply-overflow flag, registered with result.
- zero  out  1  result==0, registered with result.
- neg  out  1  result[WIDTH-1], registered with result.
- busy  out  1  high while in MUL state.

## Operation
- Handshake: an operation is accepted on a rising edge where in_valid & in_ready. Operands, op and use_acc are sampled only at acceptance.
- Opcodes (A = acc when use_acc, else a), all arithmetic modulo 2^WIDTH:
  - 000 ADD: A+B; carry = bit WIDTH of the sum.
  - 001 SUB: A-B; carry = 1 when A>=B (no borrow).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 MUL: low WIDTH bits of A*B (unsigned); carry = 1 if the upper WIDTH bits are non-zero.
  - 110 LOAD: result = B.
  - 111 CLR: result = 0.
  - For ops 010, 011, 100, 110 and 111, carry = 0.
- Accumulator: every completed operation writes result into acc. acc is not directly visible; LOAD followed by an op with use_acc chains values.
- FSM states:
  - IDLE: a non-MUL op completes on the acceptance edge and sets out_valid_q. A MUL op goes to MUL, loading a multiplicand register (2·WIDTH bits), a multiplier register, a product register = 0 and a counter = WIDTH.
  - MUL: each cycle, if the multiplier LSB is 1 the multiplicand is added to the product. Then the multiplicand shifts left, the multiplier shifts right and the counter decrements. When the counter reaches 1, the final step writes result, flags and acc, sets out_valid_q, and returns to IDLE.
- out_valid = out_valid_q & ena. out_valid_q clears on the first ena-high edge after it was set, so exactly one visible pulse occurs per operation.
- ena low: state, counter, acc, result, flags and out_valid_q all hold; in_ready = 0; no acceptance.

## Timing
- Reset (rst_n low at an edge): state = IDLE, acc = 0, result = 0, carry = 0, zero = 1, neg = 0, out_valid_q = 0, busy = 0. in_ready is 0 while rst_n is low.
- Reset mid-MUL aborts the multiply; no out_valid is produced for the aborted op.
- Non-MUL latency: accepted at edge N → result and out_valid valid in cycle N+1. in_ready stays high, giving back-to-back throughput of 1 op/cycle.
- MUL latency: accepted at edge N → busy high and in_ready low in cycles N+1..N+WIDTH. The result and out_valid appear in cycle N+WIDTH+1, where in_ready is high again.
- use_acc back-to-back: an op accepted at edge N+1 with use_acc sees the acc written by the op accepted at edge N. No bubble.
- in_valid while in_ready is low: ignored. The requester must hold the request.
- Output signals result, flags and acc change only on completion edges.

## Test plan
- Reset: rst_n low 2 cycles with ena=1 → result=0, zero=1, carry=0, out_valid=0. in_ready=0 during reset and 1 on the cycle after release.
- ADD/SUB, WIDTH=8: ADD a=0xF0 b=0x20 → result 0x10, carry=1, out_valid 1 cycle later. SUB a=0x05 b=0x07 → 0xFE, carry=0, neg=1.
- Chaining: LOAD b=0x03, then ADD use_acc=1 b=0x04, then XOR use_acc=1 b=0x07, issued back-to-back → results 0x03, 0x07, 0x00 (zero=1) on three consecutive cycles.
- MUL: a=0x12 b=0x10 → busy for 8 cycles, in_ready low, then result 0x20, carry=1. a=0x0F b=0x0F → 0xE1, carry=0. An in_valid presented during busy is ignored.
- ena stall: drop ena for 3 cycles mid-MUL, and separately the cycle after an ADD acceptance → counter frozen and no out_valid while ena is low. Exactly one out_valid pulse appears after ena returns, with the correct value.
- Reset mid-MUL: assert rst_n low at cycle 4 of a MUL → no out_valid; acc=0. Then ADD use_acc=1 b=0x01 → result 0x01.

Source files
------------

// File: rtl/alu_seq_acc.sv
// Sequential ALU with accumulator chaining, valid/ready operand handshake,
// registered result/flags and an iterative shift-add multiplier.
module alu_seq_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_MUL  = 3'b101,
    OP_LOAD = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               ov_q, ov_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   alu_val;
  logic               alu_c;
  logic [2*WIDTH-1:0] prod_step;
  logic               done;
  logic [WIDTH-1:0]   done_val;
  logic               done_c;

  assign in_ready  = (state_q == IDLE) & ena & rst_n;
  assign out_valid = ov_q & ena;
  assign busy      = (state_q == MUL);
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

  always_comb begin
    op_a    = use_acc ? acc_q : a;
    sum     = {1'b0, op_a} + {1'b0, b};
    diff    = {1'b0, op_a} - {1'b0, b};
    alu_val = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD:  begin alu_val = sum[WIDTH-1:0];  alu_c = sum[WIDTH];   end
      OP_SUB:  begin alu_val = diff[WIDTH-1:0]; alu_c = ~diff[WIDTH]; end
      OP_AND:  alu_val = op_a & b;
      OP_OR:   alu_val = op_a | b;
      OP_XOR:  alu_val = op_a ^ b;
      OP_LOAD: alu_val = b;
      default: alu_val = '0;
    endcase
  end

  // Partial product including the current multiplier bit; the last MUL step
  // commits this value directly so the result lands without an extra cycle.
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ov_d     = ov_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    done     = 1'b0;
    done_val = '0;
    done_c   = 1'b0;

    if (ena) begin
      ov_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              state_d  = MUL;
              mcand_d  = (2*WIDTH)'(op_a);
              mplier_d = b;
              prod_d   = '0;
              cnt_d    = CW'(WIDTH);
            end else begin
              done     = 1'b1;
              done_val = alu_val;
              done_c   = alu_c;
            end
          end
        end
        MUL: begin
          prod_d   = prod_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d  = IDLE;
            done     = 1'b1;
            done_val = prod_step[WIDTH-1:0];
            done_c   = |prod_step[2*WIDTH-1:WIDTH];
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (done) begin
      result_d = done_val;
      acc_d    = done_val;
      carry_d  = done_c;
      zero_d   = (done_val == '0);
      neg_d    = done_val[WIDTH-1];
      ov_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
      ov_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ov_q     <= ov_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_acc.sv
// Bench for alu_seq_acc: directed scenarios plus randomized traffic checked
// against a cycle-level arithmetic reference model.
module tb_alu_seq_acc;

  localparam int W = 8;
  localparam int unsigned MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n, ena, in_valid, in_ready, use_acc;
  logic [2:0]   op;
  logic [W-1:0] a, b, result;
  logic         out_valid, carry, zero, neg, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int unsigned m_acc, m_res, m_mul_res;
  bit          m_carry, m_ov, m_mul_c;
  int          m_mul_left;

  always #5 clk = ~clk;

  alu_seq_acc #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .use_acc  (use_acc),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .neg      (neg),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [2:0] o, input int unsigned x, input int unsigned y,
                                 output int unsigned r, output bit c);
    int unsigned full;
    c = 1'b0;
    case (o)
      3'd0: begin full = x + y; r = full & MASK; c = (full > MASK); end
      3'd1: begin r = (x - y) & MASK; c = (x >= y); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin full = x * y; r = full & MASK; c = ((full >> W) != 0); end
      3'd6: r = y;
      default: r = 0;
    endcase
  endfunction

  task automatic model_reset();
    m_acc = 0; m_res = 0; m_carry = 0; m_ov = 0; m_mul_left = 0;
    m_mul_res = 0; m_mul_c = 0;
  endtask

  task automatic commit(input int unsigned r, input bit c);
    m_res = r; m_acc = r; m_carry = c; m_ov = 1;
  endtask

  // Drive one cycle of inputs, check visible outputs, then advance the model
  // across the coming rising edge.
  task automatic step(input bit r, input bit e, input bit v, input logic [2:0] o,
                      input bit u, input int unsigned av, input int unsigned bv);
    int unsigned rr;
    bit          cc;
    @(negedge clk);
    rst_n = r; ena = e; in_valid = v; op = o; use_acc = u;
    a = W'(av); b = W'(bv);
    #1;
    check("in_ready",  in_ready,  (m_mul_left == 0) && e && r);
    check("out_valid", out_valid, m_ov && e);
    check("busy",      busy,      m_mul_left != 0);
    check("result",    result,    m_res);
    check("carry",     carry,     m_carry);
    check("zero",      zero,      m_res == 0);
    check("neg",       neg,       (m_res >> (W - 1)) & 1);
    if (!r) begin
      model_reset();
    end else if (e) begin
      m_ov = 0;
      if (m_mul_left > 0) begin
        m_mul_left--;
        if (m_mul_left == 0) commit(m_mul_res, m_mul_c);
      end else if (v) begin
        ref_op(o, u ? m_acc : (av & MASK), bv & MASK, rr, cc);
        if (o == 3'd5) begin
          m_mul_left = W; m_mul_res = rr; m_mul_c = cc;
        end else begin
          commit(rr, cc);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 3'd0, 0, 0, 0);
  endtask

  initial begin
    int pulses;
    rst_n = 0; ena = 1; in_valid = 0; op = '0; use_acc = 0; a = '0; b = '0;
    model_reset();
    @(posedge clk);

    // Reset held two cycles
    step(0, 1, 0, 3'd0, 0, 0, 0);
    step(0, 1, 0, 3'd0, 0, 0, 0);
    check("rst_ready", in_ready, 0);
    check("rst_zero", zero, 1);
    idle(1);
    check("rel_ready", in_ready, 1);
    check("rel_result", result, 0);

    // ADD with carry, SUB with borrow
    step(1, 1, 1, 3'd0, 0, 'hF0, 'h20);
    idle(1);
    check("add_res", result, 'h10);
    check("add_c", carry, 1);
    check("add_ov", out_valid, 1);
    step(1, 1, 1, 3'd1, 0, 'h05, 'h07);
    idle(1);
    check("sub_res", result, 'hFE);
    check("sub_c", carry, 0);
    check("sub_neg", neg, 1);

    // Back-to-back accumulator chain
    step(1, 1, 1, 3'd6, 0, 0, 'h03);
    step(1, 1, 1, 3'd0, 1, 0, 'h04);
    check("chain_load", result, 'h03);
    step(1, 1, 1, 3'd4, 1, 0, 'h07);
    check("chain_add", result, 'h07);
    idle(1);
    check("chain_xor", result, 'h00);
    check("chain_zero", zero, 1);
    check("chain_ov", out_valid, 1);

    // MUL with overflow; requests during busy must be ignored
    step(1, 1, 1, 3'd5, 0, 'h12, 'h10);
    for (int i = 0; i < W; i++) begin
      step(1, 1, 1, 3'd0, 0, 'h01, 'h01);
      check("mul_busy", busy, 1);
    end
    idle(1);
    check("mul_res", result, 'h20);
    check("mul_c", carry, 1);
    check("mul_ready", in_ready, 1);
    step(1, 1, 1, 3'd5, 0, 'h0F, 'h0F);
    idle(W + 1);
    check("mul2_res", result, 'hE1);
    check("mul2_c", carry, 0);

    // ena stall mid-MUL: exactly one pulse afterwards
    pulses = 0;
    step(1, 1, 1, 3'd5, 0, 'h03, 'h05);
    for (int i = 0; i < 3; i++) begin step(1, 1, 0, 3'd0, 0, 0, 0); pulses += int'(out_valid); end
    for (int i = 0; i < 3; i++) begin step(1, 0, 0, 3'd0, 0, 0, 0); pulses += int'(out_valid); end
    for (int i = 0; i < W; i++) begin step(1, 1, 0, 3'd0, 0, 0, 0); pulses += int'(out_valid); end
    check("stall_mul_pulses", pulses, 1);
    check("stall_mul_res", result, 'h0F);

    // ena stall the cycle after an ADD acceptance
    pulses = 0;
    step(1, 1, 1, 3'd0, 0, 'h01, 'h02);
    for (int i = 0; i < 3; i++) begin step(1, 0, 0, 3'd0, 0, 0, 0); pulses += int'(out_valid); end
    for (int i = 0; i < 3; i++) begin step(1, 1, 0, 3'd0, 0, 0, 0); pulses += int'(out_valid); end
    check("stall_add_pulses", pulses, 1);
    check("stall_add_res", result, 'h03);

    // Reset in cycle 4 of a MUL aborts it
    pulses = 0;
    step(1, 1, 1, 3'd5, 0, 'h12, 'h10);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 3'd0, 0, 0, 0);
    step(0, 1, 0, 3'd0, 0, 0, 0);
    for (int i = 0; i < W + 2; i++) begin step(1, 1, 0, 3'd0, 0, 0, 0); pulses += int'(out_valid); end
    check("abort_pulses", pulses, 0);
    step(1, 1, 1, 3'd0, 1, 0, 'h01);
    idle(1);
    check("abort_acc", result, 'h01);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, $urandom_range(0, MASK), $urandom_range(0, MASK));
    end
    idle(W + 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
